temporizer_core: RTL

//  Countdown timer that feeds the display path. Holds remaining time in whole

---
 rtl/temporizer_core.sv | 101 ++++++++++
 1 files changed

// File: rtl/temporizer_core.sv
// Countdown timer with a 1 s prescaler, run/pause/finish states and
// single-cycle load/start/stop requests.
module temporizer_core #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned MAX_TIME      = 5999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] _time,
    output logic [1:0]  state,
    output logic        sec_tick,
    output logic        done
);

    localparam int unsigned CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST  = CW'(TICKS_PER_SEC - 1);
    localparam logic [15:0]   MAX_T = 16'(MAX_TIME);

    typedef enum logic [1:0] {
        S_CONT = 2'b00,
        S_DET  = 2'b01,
        S_FIN  = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic          wrap;
    logic [15:0]   clamped;

    assign wrap    = (cnt_q == LAST);
    assign clamped = (load_value > MAX_T) ? MAX_T : load_value;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        tick_d  = wrap;
        done_d  = 1'b0;
        if (load) begin
            // a load always pauses and restarts the second boundary
            time_d  = clamped;
            state_d = S_DET;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_DET: begin
                    if (!stop && start && time_q != 16'd0) begin
                        state_d = S_CONT;
                        cnt_d   = '0;
                    end
                end
                S_CONT: begin
                    if (stop) begin
                        state_d = S_DET;
                    end else if (wrap && time_q != 16'd0) begin
                        time_d = time_q - 16'd1;
                        if (time_q == 16'd1) begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    time_d = 16'd0;
                end
                default: begin
                    state_d = S_DET;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DET;
            time_q  <= 16'd0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign _time    = time_q;
    assign state    = state_q;
    assign sec_tick = tick_q;
    assign done     = done_q;

endmodule
